// File: rtl/mem_access.sv
// mem_access: memory-access stage of the RV32I pipeline.
// Holds the byte-writable data RAM. It performs stores, issues synchronous
// loads with size/sign extraction, and registers the write-back bundle.
// A monitor port gives the debug controller word access while the CPU is idle.
module mem_access #(
    parameter int DMEM_AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_ld_ma,
    input  logic               cmd_st_ma,
    input  logic               wbk_rd_reg_ma,
    input  logic [4:0]         rd_adr_ma,
    input  logic [31:0]        rd_data_ma,
    input  logic [31:0]        st_data_ma,
    input  logic [2:0]         ldst_code_ma,
    output logic               wbk_rd_reg_wb,
    output logic [4:0]         rd_adr_wb,
    output logic [31:0]        rd_data_wb,
    output logic               dmem_fault_wb,
    input  logic               dmem_radr_en_mon,
    input  logic               dmem_we_mon,
    input  logic [DMEM_AW-1:0] dmem_adr_mon,
    input  logic [31:0]        dmem_wdata_mon,
    output logic [31:0]        dmem_rdata_mon
);

    localparam int DEPTH = 1 << DMEM_AW;

    logic [31:0] ram [DEPTH];

    logic [DMEM_AW-1:0] widx;
    logic [1:0]         bofs;
    logic               ill_ld;
    logic               ill_st;
    logic               fault;
    logic               st_en;
    logic               mon_ok;
    logic [3:0]         byte_en;
    logic [31:0]        st_wdata;

    logic [31:0]        ld_word_p1;
    logic [1:0]         ld_bofs_p1;
    logic [2:0]         ld_code_p1;
    logic               ld_flag_p1;
    logic [31:0]        alu_data_p1;

    // Shift the raw word down to the addressed lane and extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  ofs,
                                                 input logic [2:0]  code);
        logic [31:0]        sh;
        logic signed [7:0]  sb;
        logic signed [15:0] shw;
        logic signed [31:0] ext;
        sh  = word >> {ofs, 3'b000};
        sb  = sh[7:0];
        shw = sh[15:0];
        case (code)
            3'b000:  ext = sb;
            3'b001:  ext = shw;
            3'b100:  ext = {24'd0, sh[7:0]};
            3'b101:  ext = {16'd0, sh[15:0]};
            default: ext = sh;
        endcase
        return ext;
    endfunction

    assign widx   = rd_data_ma[DMEM_AW+1:2];
    assign bofs   = rd_data_ma[1:0];
    assign mon_ok = ~(cmd_ld_ma | cmd_st_ma);

    // Decode legality, byte enables and lane-replicated store data.
    always_comb begin
        ill_ld   = 1'b1;
        ill_st   = 1'b1;
        byte_en  = 4'b1111;
        st_wdata = st_data_ma;
        case (ldst_code_ma)
            3'b000: begin ill_ld = 1'b0;    ill_st = 1'b0;    end
            3'b001: begin ill_ld = bofs[0]; ill_st = bofs[0]; end
            3'b010: begin ill_ld = |bofs;   ill_st = |bofs;   end
            3'b100: begin ill_ld = 1'b0;    ill_st = 1'b1;    end
            3'b101: begin ill_ld = bofs[0]; ill_st = 1'b1;    end
            default: begin ill_ld = 1'b1;   ill_st = 1'b1;    end
        endcase
        case (ldst_code_ma[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << bofs;
                st_wdata = {4{st_data_ma[7:0]}};
            end
            2'b01: begin
                byte_en  = 4'b0011 << bofs;
                st_wdata = {2{st_data_ma[15:0]}};
            end
            default: begin
                byte_en  = 4'b1111;
                st_wdata = st_data_ma;
            end
        endcase
    end

    assign fault = (cmd_ld_ma & ill_ld) | (cmd_st_ma & ill_st);
    assign st_en = cmd_st_ma & ~fault;

    // RAM write port: CPU stores take priority, monitor writes only when idle.
    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    ram[widx][8*i +: 8] <= st_wdata[8*i +: 8];
            end
        end else if (mon_ok && dmem_we_mon) begin
            ram[dmem_adr_mon] <= dmem_wdata_mon;
        end
    end

    // MA -> WB boundary: raw load word and extraction controls, data only.
    always_ff @(posedge clk) begin
        ld_word_p1  <= ram[widx];
        ld_bofs_p1  <= bofs;
        ld_code_p1  <= ldst_code_ma;
        alu_data_p1 <= rd_data_ma;
    end

    // MA -> WB boundary: write-back control bundle and fault pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbk_rd_reg_wb <= 1'b0;
            rd_adr_wb     <= 5'd0;
            dmem_fault_wb <= 1'b0;
            ld_flag_p1    <= 1'b0;
        end else begin
            wbk_rd_reg_wb <= wbk_rd_reg_ma & ~fault;
            rd_adr_wb     <= rd_adr_ma;
            dmem_fault_wb <= fault;
            ld_flag_p1    <= cmd_ld_ma;
        end
    end

    // Monitor read: read-first against a same-cycle write, holds until next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dmem_rdata_mon <= 32'd0;
        else if (mon_ok && dmem_radr_en_mon)
            dmem_rdata_mon <= ram[dmem_adr_mon];
    end

    // Gating on the reset-cleared flag keeps rd_data_wb at zero in reset.
    assign rd_data_wb = ld_flag_p1 ? load_extract(ld_word_p1, ld_bofs_p1, ld_code_p1)
                                   : (rst_n ? alu_data_p1 : 32'd0);

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized bench for mem_access against a byte-level memory model.
module tb_mem_access;

    localparam int AW = 12;
    localparam int MB = 4 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma;
    logic [4:0]  rd_adr_ma;
    logic [31:0] rd_data_ma, st_data_ma;
    logic [2:0]  ldst_code_ma;
    logic        wbk_rd_reg_wb;
    logic [4:0]  rd_adr_wb;
    logic [31:0] rd_data_wb;
    logic        dmem_fault_wb;
    logic        dmem_radr_en_mon, dmem_we_mon;
    logic [AW-1:0] dmem_adr_mon;
    logic [31:0] dmem_wdata_mon, dmem_rdata_mon;

    logic [7:0]  mdl [MB];
    logic [31:0] exp_mon;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    mem_access #(.DMEM_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma), .wbk_rd_reg_ma(wbk_rd_reg_ma),
        .rd_adr_ma(rd_adr_ma), .rd_data_ma(rd_data_ma), .st_data_ma(st_data_ma),
        .ldst_code_ma(ldst_code_ma),
        .wbk_rd_reg_wb(wbk_rd_reg_wb), .rd_adr_wb(rd_adr_wb), .rd_data_wb(rd_data_wb),
        .dmem_fault_wb(dmem_fault_wb),
        .dmem_radr_en_mon(dmem_radr_en_mon), .dmem_we_mon(dmem_we_mon),
        .dmem_adr_mon(dmem_adr_mon), .dmem_wdata_mon(dmem_wdata_mon),
        .dmem_rdata_mon(dmem_rdata_mon)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Access size in bytes from funct3; 0 means no such size.
    function automatic int acc_size(input logic [2:0] code);
        case (code[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_fault(input bit ld, input bit st, input logic [31:0] addr,
                                    input logic [2:0] code);
        int sz;
        if (!ld && !st) return 1'b0;
        sz = acc_size(code);
        if (sz == 0) return 1'b1;
        if (code[2] && (st || sz == 4)) return 1'b1;
        if ((int'(addr[1:0]) % sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {mdl[4*w+3], mdl[4*w+2], mdl[4*w+1], mdl[4*w]};
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [2:0] code);
        int sz, base;
        logic [31:0] v;
        sz   = acc_size(code);
        base = int'(addr % MB);
        v    = 32'd0;
        for (int i = 0; i < sz; i++) v = v | (32'(mdl[base+i]) << (8*i));
        if (!code[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
        return v;
    endfunction

    // One clock: drive inputs, update model, then check the WB-cycle outputs.
    task automatic do_cycle(input bit ld, input bit st, input bit wbk, input logic [4:0] rd,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [2:0] code, input bit mre, input bit mwe,
                            input logic [AW-1:0] madr, input logic [31:0] mwd);
        bit f;
        bit cpu;
        logic [31:0] exp_data;
        int sz, base;
        f   = is_fault(ld, st, addr, code);
        cpu = ld | st;
        exp_data = ld ? exp_load(addr, code) : addr;
        if (!cpu && mre) exp_mon = model_word(int'(madr));
        if (!cpu && mwe)
            for (int i = 0; i < 4; i++) mdl[4*int'(madr)+i] = mwd[8*i +: 8];
        if (st && !f) begin
            sz   = acc_size(code);
            base = int'(addr % MB);
            for (int i = 0; i < sz; i++) mdl[base+i] = sdata[8*i +: 8];
        end
        cmd_ld_ma = ld; cmd_st_ma = st; wbk_rd_reg_ma = wbk; rd_adr_ma = rd;
        rd_data_ma = addr; st_data_ma = sdata; ldst_code_ma = code;
        dmem_radr_en_mon = mre; dmem_we_mon = mwe; dmem_adr_mon = madr; dmem_wdata_mon = mwd;
        @(posedge clk);
        #1;
        check("wbk", 32'(wbk_rd_reg_wb), 32'(wbk & ~f));
        check("rd_adr", 32'(rd_adr_wb), 32'(rd));
        check("fault", 32'(dmem_fault_wb), 32'(f));
        if (!(ld && f)) check("rd_data", rd_data_wb, exp_data);
        check("mon_rdata", dmem_rdata_mon, exp_mon);
    endtask

    task automatic cpu_op(input bit ld, input bit st, input bit wbk, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [2:0] code);
        do_cycle(ld, st, wbk, rd, addr, sdata, code, 1'b0, 1'b0, '0, 32'd0);
    endtask

    task automatic mon_op(input bit mre, input bit mwe, input logic [AW-1:0] madr,
                          input logic [31:0] mwd);
        do_cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 3'd0, mre, mwe, madr, mwd);
    endtask

    initial begin
        int r;
        bit ld, st, mre, mwe;
        logic [31:0] a;
        logic [2:0] code;

        rst_n = 1'b0;
        cmd_ld_ma = 0; cmd_st_ma = 0; wbk_rd_reg_ma = 0; rd_adr_ma = 0;
        rd_data_ma = 0; st_data_ma = 0; ldst_code_ma = 0;
        dmem_radr_en_mon = 0; dmem_we_mon = 0; dmem_adr_mon = 0; dmem_wdata_mon = 0;
        exp_mon = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wbk", 32'(wbk_rd_reg_wb), 32'd0);
        check("rst_rd_adr", 32'(rd_adr_wb), 32'd0);
        check("rst_rd_data", rd_data_wb, 32'd0);
        check("rst_fault", 32'(dmem_fault_wb), 32'd0);
        check("rst_mon", dmem_rdata_mon, 32'd0);
        rst_n = 1'b1;

        // Fill the exercised region through the monitor so the model knows it.
        for (int w = 0; w < 128; w++) mon_op(1'b0, 1'b1, AW'(w), $urandom);

        cpu_op(0, 1, 0, 0, 32'h100, 32'hDEADBEEF, 3'b010);
        cpu_op(1, 0, 1, 5, 32'h100, 0, 3'b010);
        check("lw_const", rd_data_wb, 32'hDEADBEEF);
        check("lw_rd5", 32'(rd_adr_wb), 32'd5);

        cpu_op(0, 1, 0, 0, 32'h100, 32'h11223344, 3'b010);
        cpu_op(0, 1, 0, 0, 32'h103, 32'h00000080, 3'b000);
        cpu_op(1, 0, 1, 1, 32'h103, 0, 3'b000);
        check("lb_const", rd_data_wb, 32'hFFFFFF80);
        cpu_op(1, 0, 1, 1, 32'h103, 0, 3'b100);
        check("lbu_const", rd_data_wb, 32'h00000080);
        cpu_op(1, 0, 1, 1, 32'h100, 0, 3'b010);
        check("lw_after_sb", rd_data_wb, 32'h80223344);

        cpu_op(0, 1, 0, 0, 32'h102, 32'h00008001, 3'b001);
        cpu_op(1, 0, 1, 2, 32'h102, 0, 3'b001);
        check("lh_const", rd_data_wb, 32'hFFFF8001);
        cpu_op(1, 0, 1, 2, 32'h102, 0, 3'b101);
        check("lhu_const", rd_data_wb, 32'h00008001);
        cpu_op(1, 0, 1, 2, 32'h100, 0, 3'b001);
        check("lh_low", rd_data_wb, 32'h00003344);

        cpu_op(1, 0, 1, 7, 32'h101, 0, 3'b010);
        check("misal_lw_fault", 32'(dmem_fault_wb), 32'd1);
        cpu_op(0, 1, 0, 0, 32'h103, 32'h0000FFFF, 3'b001);
        check("misal_sh_fault", 32'(dmem_fault_wb), 32'd1);
        cpu_op(1, 0, 1, 3, 32'h100, 0, 3'b010);
        check("sh_unchanged", rd_data_wb, 32'h80013344);

        mon_op(0, 1, 3, 32'h0A5A5A5A);
        mon_op(1, 0, 3, 0);
        check("mon_read", dmem_rdata_mon, 32'h0A5A5A5A);
        do_cycle(0, 1, 0, 0, 32'h200, 32'h5555AAAA, 3'b010, 0, 1, 3, 32'hFFFFFFFF);
        mon_op(1, 0, 3, 0);
        check("mon_drop", dmem_rdata_mon, 32'h0A5A5A5A);

        cpu_op(0, 1, 0, 0, 32'h4000, 32'hCAFEF00D, 3'b010);
        cpu_op(1, 0, 1, 4, 32'h0, 0, 3'b010);
        check("wrap_lw", rd_data_wb, 32'hCAFEF00D);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFFC000);
            ld = 0; st = 0; mre = 0; mwe = 0;
            code = 3'($urandom_range(0, 7));
            if (r <= 2) ld = 1;
            else if (r <= 4) begin
                st = 1;
                if ($urandom_range(0, 3) != 0) code = 3'($urandom_range(0, 2));
            end else if (r == 5) a = $urandom;
            else if (r >= 7) begin
                mre = (r != 8);
                mwe = (r != 7);
                if ($urandom_range(0, 2) == 0) begin
                    st = 1;
                    code = 3'b010;
                    a[1:0] = 2'b00;
                end
            end
            do_cycle(ld, st, (r == 5) || (ld && $urandom_range(0, 3) != 0),
                     5'($urandom_range(0, 31)), a, $urandom, code,
                     mre, mwe, AW'($urandom_range(0, 127)), $urandom);
        end

        cpu_op(0, 0, 1, 9, 32'h12345678, 0, 3'b000);
        mon_op(1, 0, 3, 0);
        cpu_op(0, 0, 1, 9, 32'h12345678, 0, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wbk", 32'(wbk_rd_reg_wb), 32'd0);
        check("arst_rd_adr", 32'(rd_adr_wb), 32'd0);
        check("arst_rd_data", rd_data_wb, 32'd0);
        check("arst_fault", 32'(dmem_fault_wb), 32'd0);
        check("arst_mon", dmem_rdata_mon, 32'd0);
        exp_mon = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cpu_op(0, 0, 0, 0, 32'h0, 0, 3'b000);
        cpu_op(1, 0, 1, 4, 32'h4000, 0, 3'b010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access (MA) stage of the RV32I pipeline. It receives the EX-stage outputs (`cmd_ld_ma`, `cmd_st_ma`, `wbk_rd_reg_ma`, `rd_adr_ma`, `rd_data_ma`, `st_data_ma`, `ldst_code_ma`) and owns the word-organised, byte-writable data RAM. It performs stores, issues synchronous loads with size and sign extraction, and registers the write-back bundle for the WB stage. A monitor port gives the debug controller read/write access to the RAM.

## Interface
- `DMEM_AW`, 12, word-address width; RAM size is 2^DMEM_AW × 32 bit.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_ld_ma` in 1: load in MA this cycle; already qualified by `cpu_stat_ex`.
- `cmd_st_ma` in 1: store in MA this cycle; already qualified.
- `wbk_rd_reg_ma` in 1: instruction writes `rd`.
- `rd_adr_ma` in 5: destination register.
- `rd_data_ma` in 32: byte address for ld/st; otherwise the result to write back.
- `st_data_ma` in 32: store data, right-aligned.
- `ldst_code_ma` in 3: funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `wbk_rd_reg_wb` out 1: write-back enable.
- `rd_adr_wb` out 5: write-back register.
- `rd_data_wb` out 32: write-back data.
- `dmem_fault_wb` out 1: one-cycle pulse for a misaligned or illegal-size ld/st.
- `dmem_radr_en_mon` in 1: monitor read strobe.
- `dmem_we_mon` in 1: monitor word write.
- `dmem_adr_mon` in DMEM_AW: monitor word address.
- `dmem_wdata_mon` in 32: monitor write data.
- `dmem_rdata_mon` out 32: monitor read data.

## Operation
**Address mapping**
- Word index is `rd_data_ma[DMEM_AW+1:2]`. Higher address bits are ignored, so accesses wrap modulo the RAM size.
- `bofs = rd_data_ma[1:0]`.

**Legality**
- Halfword (001/101) with `bofs[0]=1` is illegal.
- Word (010) with `bofs≠0` is illegal.
- Codes 011, 110 and 111 are illegal for both loads and stores.
- Code 1xx is illegal for stores.
- `fault = (cmd_ld_ma|cmd_st_ma) & illegal`.

**Store** (`cmd_st_ma & ~fault`)
- Byte enables:
  - SB: `1<<bofs`.
  - SH: `4'b0011<<bofs`.
  - SW: `4'b1111`.
- Write data is `st_data_ma` replicated into lanes: byte ×4, half ×2.
- The write occurs at the clock edge ending the MA cycle; unselected bytes are unchanged.

**Load** (`cmd_ld_ma`)
- The RAM is read with the MA-cycle address.
- `bofs`, `ldst_code_ma` and a load flag are registered.
- In the WB cycle the raw word is shifted right by 8·bofs.
  - B/H are sign-extended from bit 7/15.
  - BU/HU are zero-extended.
  - W passes through unchanged.

**Write-back registers** (loaded every cycle)
- `wbk_rd_reg_wb <= wbk_rd_reg_ma & ~fault`.
- `rd_adr_wb <= rd_adr_ma`.
- Non-load data register `<= rd_data_ma`.
- `rd_data_wb` = extracted load data when the registered load flag is set, otherwise the registered data.
- `dmem_fault_wb <= fault`.

**Monitor port**
- Monitor accesses are honoured only when `cmd_ld_ma|cmd_st_ma` is 0. On a collision the CPU wins and the monitor access is dropped silently.
- A monitor write writes the full word.
- On a monitor read, `dmem_rdata_mon` updates one cycle after the strobe and holds until the next honoured read.
- If read and write are issued together, the read returns the old data (read-first).

**Reset**
- `wbk_rd_reg_wb`, `rd_adr_wb`, `rd_data_wb`, `dmem_fault_wb`, the load flag and `dmem_rdata_mon` reset to 0.
- RAM contents are not reset.

## Timing
- Stores:
  - Zero-bubble; the write commits at the end of the MA cycle.
  - A load in the following cycle returns the new data; no bypass is required.
- Loads and ALU results:
  - Load data is valid on `rd_data_wb` in cycle MA+1; latency is 1.
  - ALU results also appear in cycle MA+1, so WB timing is uniform.
- Back-to-back ld/st every cycle is supported; there is no stall output.
- `dmem_fault_wb` asserts in cycle MA+1, aligned with the suppressed write-back.
- A bubble (`cmd_* = 0`, `wbk_rd_reg_ma = 0`) produces `wbk_rd_reg_wb = 0` in the next cycle.
- Reset mid-operation:
  - WB outputs clear asynchronously.
  - A store whose edge coincides with reset assertion may or may not commit; software must not rely on it.

## Test plan
- SW, then LW, both to 0x100:
  - SW 0xDEADBEEF to 0x100.
  - Next cycle LW 0x100, rd=5 → in cycle+1 `rd_data_wb=0xDEADBEEF`, `rd_adr_wb=5`, `wbk_rd_reg_wb=1`.
- Byte store and sign extraction:
  - SB 0x80 to 0x103 over word 0x11223344.
  - LB 0x103 → 0xFFFFFF80.
  - LBU 0x103 → 0x00000080.
  - LW 0x100 → 0x80223344.
- Halfword store and sign extraction:
  - SH 0x8001 to 0x102.
  - LH 0x102 → 0xFFFF8001.
  - LHU 0x102 → 0x00008001.
  - LH 0x100 → 0x00003344.
- Misalignment:
  - LW 0x101 with rd=7 → `dmem_fault_wb=1`, `wbk_rd_reg_wb=0`.
  - SH 0x103 → RAM unchanged (verified by LW) and `dmem_fault_wb=1`.
- Monitor port:
  - Monitor write 0x0A5A5A5A at word 3, then monitor read word 3 → `dmem_rdata_mon=0x0A5A5A5A` one cycle later.
  - Monitor write issued with `cmd_st_ma=1` → dropped.
- Wrap-around and reset:
  - With DMEM_AW=12, SW to 0x4000 then LW 0x0 returns the same data.
  - Asserting `rst_n` low mid-stream zeroes all WB outputs immediately.
